// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default parameters for the fetch/data memory arbiter
package mem_arb_pkg;

    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_starve.sv
// rtl/mem_arb_starve.sv - fetch starvation counter, built only when MEM_ARB_FAIR_EN is defined
module mem_arb_starve (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && (count != 4'hF)) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-port memory arbiter between instruction fetch and data access
// Optional fetch fairness enabled by defining MEM_ARB_FAIR_EN.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ack,
    output logic [15:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
        $error("mem_arb: MEM_LAT must be 1..7");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_arb: STARVE_MAX must be 1..15");
    end

    state_t     state;
    owner_t     owner;
    logic [2:0] cnt;
    logic       grant;
    logic       fetch_win;

    assign grant    = (state == IDLE) && (if_req || d_req);
    assign if_stall = if_req & ~if_ack;

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] starve_cnt;

    // Fetch overrides data priority once it has been passed over STARVE_MAX times.
    assign fetch_win = if_req && (!d_req || (starve_cnt == 4'(STARVE_MAX)));

    mem_arb_starve u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (grant && !fetch_win && if_req),
        .clr   (grant && fetch_win),
        .count (starve_cnt)
    );
`else
    assign fetch_win = if_req && !d_req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            cnt       <= 3'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            if_rdata  <= 16'h0000;
            d_rdata   <= 16'h0000;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= fetch_win ? OWN_IF : OWN_D;
                        mem_en    <= 1'b1;
                        mem_we    <= !fetch_win && d_we;
                        mem_addr  <= fetch_win ? {8'h00, if_addr} : d_addr;
                        mem_wdata <= fetch_win ? 16'h0000 : d_wdata;
                        cnt       <= 3'(MEM_LAT - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 3'd0) begin
                        if (owner == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 16'h0000;
                        mem_wdata <= 16'h0000;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb with a transaction-timing reference model
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int LAT  = MEM_LAT_DEF;
    localparam int SMAX = STARVE_MAX_DEF;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_init = 1'b1;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = 8'h00;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        if_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = 16'h0000;
    logic [15:0] d_wdata = 16'h0000;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arb #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return (a == 8'h04) ? 16'h1234 : {a, ~a};
    endfunction

    // Bench memory: combinational read, writes commit at each BUSY edge with mem_we.
    logic [15:0] bmem [256];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) bmem[i] <= init_word(8'(i));
        end else if (mem_en && mem_we) begin
            bmem[mem_addr[7:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = bmem[mem_addr[7:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant in cycle g occupies the memory in cycles g+1..g+LAT,
    // acks in g+LAT+1, and the arbiter can grant again from g+LAT+2.
    logic [15:0] ref_mem [256];
    int          cyc = 0;
    int          next_free = 0;
    int          t_g = 0;
    bit          has_txn = 0;
    bit          t_d, t_we;
    logic [15:0] t_addr, t_wd;
    int          starve = 0;
    logic [15:0] exp_ifr = 16'h0, exp_dr = 16'h0;

    always @(negedge clk) begin
        logic        e_ifack, e_dack, e_en, e_we, fw;
        logic [15:0] e_addr, e_wd;
        if (mem_init) for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        e_ifack = 0; e_dack = 0; e_en = 0; e_we = 0; e_addr = 16'h0; e_wd = 16'h0;
        if (reset) begin
            has_txn = 0; next_free = cyc + 1; starve = 0; exp_ifr = 16'h0; exp_dr = 16'h0;
        end else begin
            if (has_txn && cyc > t_g && cyc <= t_g + LAT) begin
                e_en = 1; e_we = t_we; e_addr = t_addr; e_wd = t_wd;
            end
            if (has_txn && cyc == t_g + LAT + 1) begin
                if (t_d) begin
                    e_dack = 1;
                    exp_dr = (t_we && LAT >= 2) ? t_wd : ref_mem[t_addr[7:0]];
                    if (t_we) ref_mem[t_addr[7:0]] = t_wd;
                end else begin
                    e_ifack = 1;
                    exp_ifr = ref_mem[t_addr[7:0]];
                end
                has_txn = 0;
            end
        end
        chk("cyc_if_ack", if_ack, e_ifack);
        chk("cyc_d_ack", d_ack, e_dack);
        chk("cyc_mem_en", mem_en, e_en);
        chk("cyc_mem_we", mem_we, e_we);
        chk("cyc_mem_addr", mem_addr, e_addr);
        chk("cyc_mem_wdata", mem_wdata, e_wd);
        chk("cyc_if_rdata", if_rdata, exp_ifr);
        chk("cyc_d_rdata", d_rdata, exp_dr);
        chk("cyc_if_stall", if_stall, if_req & ~e_ifack);
        if (!reset && cyc >= next_free && (if_req || d_req)) begin
            fw = if_req && (!d_req || (FAIR && starve == SMAX));
            if (fw) starve = 0;
            else if (if_req) starve++;
            has_txn = 1; t_g = cyc; t_d = !fw;
            t_we   = fw ? 1'b0 : d_we;
            t_addr = fw ? {8'h00, if_addr} : d_addr;
            t_wd   = fw ? 16'h0 : d_wdata;
            next_free = cyc + LAT + 2;
        end
        cyc++;
    end

    int   we_cnt = 0;
    int   dack_cnt = 0;
    string order = "";
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we) we_cnt++;
            if (d_ack) begin dack_cnt++; order = {order, "D"}; end
            if (if_ack) order = {order, "I"};
        end
    end

    task automatic access(input bit is_d, input bit we, input logic [15:0] addr, input logic [15:0] wd,
                          output int lat, output int stall_n);
        @(posedge clk); #1;
        if (is_d) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
        else begin if_req = 1; if_addr = addr[7:0]; end
        lat = -1; stall_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_stall) stall_n++;
            if (is_d ? d_ack : if_ack) begin lat = i; break; end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL ack_timeout: no ack for addr %0h within 20 cycles", addr);
        end
        @(posedge clk); #1;
        if_req = 0; d_req = 0; d_we = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int lat, st, n;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_if_rdata", if_rdata, 16'h0);
        chk("rst_d_ack", d_ack, 0);
        @(posedge clk); #1;
        reset = 0; mem_init = 0;

        access(0, 0, 16'h0004, 16'h0, lat, st);
        chk("fetch_lat", lat, 3);
        chk("fetch_rdata", if_rdata, 16'h1234);
        chk("fetch_stall_cycles", st, 3);

        we_cnt = 0;
        access(1, 1, 16'h0010, 16'hBEEF, lat, st);
        chk("store_we_cycles", we_cnt, 2);
        access(1, 0, 16'h0010, 16'h0, lat, st);
        chk("load_rdata", d_rdata, 16'hBEEF);
        chk("load_lat", lat, 3);

        access(1, 0, 16'h0033, 16'h0, lat, st);
        chk("load2_rdata", d_rdata, 16'h33CC);
        chk("hold_if_rdata", if_rdata, 16'h1234);

        // Request dropped after the grant edge must still complete.
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = 16'h0041;
        @(posedge clk); #1;
        d_req = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d_ack) begin n = 1; break; end
        end
        chk("abort_free_ack", n, 1);
        chk("abort_free_rdata", d_rdata, 16'h41BE);

        // Both requesters held continuously for six access slots.
        @(posedge clk); #1;
        order = "";
        if_req = 1; if_addr = 8'h08; d_req = 1; d_we = 0; d_addr = 16'h0010;
        repeat (6 * (LAT + 2)) @(posedge clk);
        #1;
        if_req = 0; d_req = 0;
        repeat (6) @(posedge clk);
        checks++;
        if (order != (FAIR ? "DDDDID" : "DDDDDD")) begin
            errors++;
            $display("FAIL grant_order: got %s expected %s", order, FAIR ? "DDDDID" : "DDDDDD");
        end

        // Reset in the second BUSY cycle of a store.
        @(posedge clk); #1;
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'hCAFE;
        @(posedge clk);
        @(posedge clk); #3;
        chk("rst_pre_mem_we", mem_we, 1);
        reset = 1; #1;
        chk("rst_async_mem_we", mem_we, 0);
        chk("rst_async_mem_en", mem_en, 0);
        chk("rst_async_mem_addr", mem_addr, 16'h0);
        d_req = 0; d_we = 0;
        @(posedge clk); #1;
        reset = 0;
        dack_cnt = 0;
        repeat (8) @(negedge clk);
        chk("rst_no_d_ack", dack_cnt, 0);
        access(1, 0, 16'h0010, 16'h0, lat, st);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_rdata", d_rdata, 16'hBEEF);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
